// File: rtl/fir_pkg.sv
// fir_pkg: shared widths and rounding/saturation helpers for the fir_* output stages
package fir_pkg;
  localparam int D_BITS = 16;
  localparam int M_BITS = 16;
  function automatic logic signed [63:0] round_shr(input logic signed [63:0] v, input int shift);
    return (v + (64'sd1 <<< (shift - 1))) >>> shift;
  endfunction
  function automatic logic signed [63:0] clamp(input logic signed [63:0] v, input int o_bits);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (o_bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] value, input int shift, input int o_bits);
    return clamp(round_shr(value, shift), o_bits);
  endfunction
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: DEPTH x WIDTH synchronous FIFO; push while full succeeds only alongside a pop
module fifo_sync #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign empty_o = count == '0;
  assign full_o = count == (AW+1)'(DEPTH);
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  // when empty, the slot just behind the read pointer still holds the last word shown
  assign dout_o = empty_o ? mem[rd_ptr - 1'b1] : mem[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din_i;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fir_dec_quant.sv
// fir_dec_quant: decimate the FIR result, round/saturate to O_BITS and buffer behind valid/ready
module fir_dec_quant #(
  parameter int D_BITS = fir_pkg::D_BITS,
  parameter int M_BITS = fir_pkg::M_BITS,
  parameter int DEC = 4,
  parameter int SHIFT = 16,
  parameter int O_BITS = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     in_valid_i,
  input  logic [D_BITS+M_BITS-1:0] y_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [O_BITS-1:0]        out_data_o,
  output logic                     sat_o,
  output logic                     ovf_o
);
  import fir_pkg::*;
  localparam int W = D_BITS + M_BITS;
  localparam int PW = DEC > 1 ? $clog2(DEC) : 1;
  localparam logic signed [W:0] HALF = (W+1)'(1) <<< (SHIFT - 1);
  logic [PW-1:0] phase;
  logic keep, s1_v, s2_v, sat_c, full, empty, pop, flush;
  logic signed [W:0] r_c, s1_r;
  logic signed [63:0] c_c;
  logic [O_BITS-1:0] s2_d;
  assign flush = rst_i | clr_i;
  assign keep = in_valid_i & (phase == '0);
  assign pop = out_valid_o & out_ready_i;
  assign out_valid_o = ~empty;
  // one extra bit of headroom keeps the rounding add from wrapping
  assign r_c = ($signed({y_i[W-1], y_i}) + HALF) >>> SHIFT;
  assign c_c = clamp(64'(s1_r), O_BITS);
  assign sat_c = c_c != 64'(s1_r);
  always_ff @(posedge clk_i) begin
    if (flush) begin
      phase <= '0;
      s1_v <= 1'b0;
      s1_r <= '0;
      s2_v <= 1'b0;
      s2_d <= '0;
      sat_o <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      if (in_valid_i) phase <= phase == PW'(DEC - 1) ? '0 : phase + 1'b1;
      s1_v <= keep;
      if (keep) s1_r <= r_c;
      s2_v <= s1_v;
      if (s1_v) s2_d <= c_c[O_BITS-1:0];
      if (s1_v & sat_c) sat_o <= 1'b1;
      if (s2_v & full & ~pop) ovf_o <= 1'b1;
    end
  end
  fifo_sync #(.DEPTH(DEPTH), .WIDTH(O_BITS)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (flush),
    .push_i  (s2_v),
    .pop_i   (out_ready_i),
    .din_i   (s2_d),
    .dout_o  (out_data_o),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule
